// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for the shared integer ALU
// One transaction in flight: accept in IDLE, evaluate in EXEC, hold the result in RESP.

module alu_core #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [OPCODE_LENGTH-1:0] op_i,
  input  logic [DATA_WIDTH-1:0]    a_i,
  input  logic [DATA_WIDTH-1:0]    b_i,
  output logic [DATA_WIDTH-1:0]    y_o
);
  always_comb begin
    y_o = '0;
    case (op_i)
      OPCODE_LENGTH'(4'b0000): y_o = a_i & b_i;
      OPCODE_LENGTH'(4'b0001): y_o = a_i | b_i;
      OPCODE_LENGTH'(4'b0010): y_o = a_i + b_i;
      OPCODE_LENGTH'(4'b0011): y_o = a_i ^ b_i;
      OPCODE_LENGTH'(4'b1000): y_o = {{(DATA_WIDTH-1){1'b0}}, (a_i == b_i)};
      default:                 y_o = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_result
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                   state_q;
  logic                     ptr_q;
  logic [DATA_WIDTH-1:0]    a_q, b_q;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic                     id_q;
  logic                     rsp_valid_q, rsp_id_q;
  logic [DATA_WIDTH-1:0]    rsp_result_q;
  logic [DATA_WIDTH-1:0]    alu_y_d;
  logic                     grant0, grant1;

  // ptr_q = 0 favours requester 0 when both are valid; a lone requester always wins.
  assign grant0 = (state_q == IDLE) && !reset && req0_valid && (!req1_valid || !ptr_q);
  assign grant1 = (state_q == IDLE) && !reset && req1_valid && (!req0_valid || ptr_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

  alu_core #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (alu_y_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q     <= grant1 ? req1_a  : req0_a;
            b_q     <= grant1 ? req1_b  : req0_b;
            op_q    <= grant1 ? req1_op : req0_op;
            id_q    <= grant1;
            ptr_q   <= grant0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_y_d;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - table-driven and scoreboard checks for alu_arbiter
// Responses are compared against a queue of expectations pushed at each accept.

module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] res;
  } exp_t;

  vec_t vecs [9];
  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b1000: return (a == b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        chk("rsp_result", rsp_result, e.res);
      end
    end
  end

  task automatic do_txn(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] exp, input bit push,
                        output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    if (id == 1'b0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id == 1'b0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        break;
      end
      tick();
      waits++;
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      chk("one_ready", {31'd0, (id == 1'b0) ? req1_ready : req0_ready}, 32'd0);
      if (push) sb_q.push_back('{id: id, res: exp});
    end
    tick();
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
      tick();
    end
    chk("drain", sb_q.size(), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          waits;
    logic [31:0] a0, b0, a1, b1;
    bit          got;
    logic        gid;

    vecs[0] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 4'b0010, 32'h0000_0001};
    vecs[2] = '{1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0000, 32'h0000_00F0};
    vecs[3] = '{1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0011, 32'h0000_FF00};
    vecs[4] = '{1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0001, 32'h0000_FFF0};
    vecs[5] = '{1'b1, 32'h0000_1234, 32'h0000_1235, 4'b1000, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'h0000_DEAD, 32'h0000_DEAD, 4'b1000, 32'h0000_0001};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 4'b0111, 32'h0000_0000};
    vecs[8] = '{1'b0, 32'h0000_0005, 32'h0000_0005, 4'b1111, 32'h0000_0000};

    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    tick(); tick();
    @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    tick();
    reset = 1'b0;

    // Single ADD with latency check, then a back-to-back accept.
    do_txn(vecs[0].id, vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].exp, 1'b1, waits);
    @(negedge clk);
    chk("exec_no_valid", {31'd0, rsp_valid}, 32'd0);
    chk("exec_ready0", {31'd0, req0_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("latency_valid", {31'd0, rsp_valid}, 32'd1);
    tick();
    do_txn(vecs[1].id, vecs[1].a, vecs[1].b, vecs[1].op, vecs[1].exp, 1'b1, waits);
    chk("b2b_accept_waits", waits, 32'd0);

    for (int i = 2; i < 9; i++)
      do_txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1'b1, waits);
    drain();

    // Contention from reset: both valid, grants must alternate starting at req0.
    reset = 1'b1;
    a0 = 32'h0000_F0F0; b0 = 32'h0000_0FF0; a1 = 32'h0000_F0F0; b1 = 32'h0000_0FF0;
    req0_a = a0; req0_b = b0; req0_op = 4'b0000; req0_valid = 1'b1;
    req1_a = a1; req1_b = b1; req1_op = 4'b0011; req1_valid = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int g = 0; g < 5; g++) begin
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      if (!got) begin
        chk("rr_timeout", 32'd0, 32'd1);
      end else begin
        gid = req1_ready;
        chk("rr_order", {31'd0, gid}, {31'd0, g[0]});
        chk("rr_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (gid == 1'b0) sb_q.push_back('{id: 1'b0, res: ref_alu(req0_op, req0_a, req0_b)});
        else             sb_q.push_back('{id: 1'b1, res: ref_alu(req1_op, req1_a, req1_b)});
      end
      tick();
      if (gid == 1'b0) begin
        a0 = a0 + 32'h0101_0011; req0_a = a0;
        if (g >= 3) req0_valid = 1'b0;
      end else begin
        b1 = b1 ^ 32'h00FF_0F00; req1_b = b1;
        if (g >= 3) req1_valid = 1'b0;
      end
    end
    drain();

    // Backpressure: result held stable, no readys until response leaves.
    rsp_ready = 1'b0;
    do_txn(1'b0, 32'h0000_1234, 32'h0000_1234, 4'b1000, 32'd1, 1'b1, waits);
    req1_a = 32'd1; req1_b = 32'd2; req1_op = 4'b0001; req1_valid = 1'b1;
    @(negedge clk);
    chk("bp_exec_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result_stable", rsp_result, 32'd1);
      chk("bp_id_stable", {31'd0, rsp_id}, 32'd0);
      chk("bp_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_in_resp", {31'd0, req1_ready}, 32'd0);
    tick();
    do_txn(1'b1, 32'd1, 32'd2, 4'b0001, 32'd3, 1'b1, waits);
    chk("bp_accept_after", waits, 32'd0);
    drain();

    // Reset while in EXEC: response discarded, pointer back to req0.
    do_txn(1'b0, 32'h10, 32'h20, 4'b0010, 32'h30, 1'b0, waits);
    reset = 1'b1;
    req0_a = 32'h0000_00FF; req0_b = 32'h0000_0F0F; req0_op = 4'b0000; req0_valid = 1'b1;
    req1_a = 32'h0000_00FF; req1_b = 32'h0000_0F0F; req1_op = 4'b0011; req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("rst_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_grant0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_grant1", {31'd0, req1_ready}, 32'd0);
    if (req0_ready) sb_q.push_back('{id: 1'b0, res: 32'h0000_000F});
    tick();
    req0_valid = 1'b0;
    do_txn(1'b1, 32'h0000_00FF, 32'h0000_0F0F, 4'b0011, 32'h0000_0FF0, 1'b1, waits);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit integer ALU (AND/OR/ADD/XOR/EQ). It accepts operand/opcode transactions from two independent requesters over valid/ready handshakes and grants the ALU round-robin. It registers one result and returns it with the requester ID over a valid/ready response channel. It instantiates the existing ALU combinationally on internally held operands, and it has exactly one transaction in flight.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a transaction
- req0_ready  out  1  requester 0 transaction accepted this cycle
- req0_a, req0_b  in  DATA_WIDTH  requester 0 operands
- req0_op  in  OPCODE_LENGTH  requester 0 operation
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the response (0/1)
- rsp_result  out  DATA_WIDTH  ALU result

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If neither valid is high, stay.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester the priority pointer selects.
  - The granted requester's ready is high combinationally in this cycle, and the transfer completes. Latch a, b, op and id into holding registers, flip the pointer to the other requester, go to EXEC.
- EXEC: the ALU evaluates the held operands. Register its output into rsp_result and the held id into rsp_id, then go to RESP.
- RESP: rsp_valid=1. On rsp_ready=1, go to IDLE. Otherwise hold with rsp_result and rsp_id stable.
- Ready signals are 0 in EXEC and RESP. At most one ready is high in any cycle.
- A requester may not lower valid or change operands while valid=1 and ready=0. A violation is undefined, and the bench must not drive it.
- ALU semantics for the held op:
  - 0000: AND
  - 0001: OR
  - 0010: ADD, modulo 2^DATA_WIDTH, carry discarded
  - 0011: XOR
  - 1000: result is 1 if a==b, else 0, zero-extended
  - Any other code: result 0. It does not error and it is still returned with the correct id.
- Priority pointer: after reset it favours requester 0. After each grant it points to the requester not just granted. A lone requester is granted regardless of the pointer, and the pointer still flips.

## Timing
- Reset values:
  - state IDLE, pointer to requester 0
  - rsp_valid 0, rsp_id 0, rsp_result 0
  - req0_ready and req1_ready 0 while reset is high
- Latency: accept at edge N (ready high in cycle N-1…N) gives rsp_valid high in cycle N+2, i.e. two cycles after the accept cycle.
- A response handshake completing in cycle M returns the FSM to IDLE at M+1. A new accept is possible in that cycle. Maximum throughput is one transaction per 3 cycles with rsp_ready held high.
- rsp_ready while rsp_valid=0 is ignored.
- Reset asserted in EXEC or RESP: the in-flight transaction is discarded and no response is produced. Next cycle all outputs are at reset values.
- A requester valid that arrives during EXEC/RESP waits. It is arbitrated in the next IDLE cycle against the then-current pointer.

## Test plan
- Single ADD: req0 a=0x7FFFFFFF, b=1, op=0010 -> req0_ready 1 cycle, rsp_valid two cycles later, rsp_result=0x80000000, rsp_id=0.
- Wrap: req1 a=0xFFFFFFFF, b=2, ADD -> rsp_result=0x00000001, rsp_id=1.
- Contention: both valid continuously from reset with distinct ops -> grants 0,1,0,1. Check rsp_id order and each result against the per-requester reference model, e.g. req0 AND 0xF0F0/0x0FF0 -> 0x00F0, req1 XOR same -> 0xFF00.
- Backpressure: rsp_ready low 5 cycles in RESP with EQ a=b=0x1234 -> rsp_valid held, rsp_result=1 stable. Both readys stay 0 until the cycle after rsp_ready rises.
- Unknown op: op=0111 -> rsp_result=0, correct rsp_id. EQ with a≠b -> 0.
- Reset mid-operation: reset in EXEC -> no rsp_valid. The pointer returns to requester 0, so with both valid the first post-reset grant goes to req0.
